// File: rtl/vram_pkg.sv
// Shared types and region constants for the VRAM write path.
package vram_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        BANK_A = 2'd0,
        BANK_B = 2'd1,
        BANK_C = 2'd2
    } bank_e;

    localparam logic [16:0] REGION_B_BASE = 17'h10000;
    localparam logic [16:0] REGION_C_BASE = 17'h14000;
    localparam logic [16:0] REGION_MIRROR = 17'h18000;

    // One buffered bank write, fully formatted at acceptance time.
    typedef struct packed {
        bank_e       bank;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO of formatted VRAM writes; head is visible combinationally.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wr_entry_t   mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/vram_write_controller.sv
// CPU write port into VRAM banks A/B/C: decode and format at acceptance,
// buffer, then drain one write per granted window cycle.
module vram_write_controller
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_wr_valid,
    output logic        cpu_wr_ready,
    input  logic [16:0] cpu_wr_addr,
    input  logic [1:0]  cpu_wr_size,
    input  logic [31:0] cpu_wr_data,
    input  logic [2:0]  bgmode,
    input  logic        vram_write_window,
    output logic [13:0] graphics_VRAM_A_waddr,
    output logic [11:0] graphics_VRAM_B_waddr,
    output logic [11:0] graphics_VRAM_C_waddr,
    output logic [31:0] graphics_VRAM_A_wdata,
    output logic [31:0] graphics_VRAM_B_wdata,
    output logic [31:0] graphics_VRAM_C_wdata,
    output logic [3:0]  graphics_VRAM_A_be,
    output logic [3:0]  graphics_VRAM_B_be,
    output logic [3:0]  graphics_VRAM_C_be,
    output logic        graphics_VRAM_A_we,
    output logic        graphics_VRAM_B_we,
    output logic        graphics_VRAM_C_we,
    output logic        wr_dropped,
    output logic        busy
);

    logic [16:0] mirrored;
    logic [16:0] obj_boundary;
    logic [3:0]  half_be;
    logic        drop;
    wr_entry_t   entry;

    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    wr_entry_t   head;

    always_comb begin
        mirrored = cpu_wr_addr;
        if (cpu_wr_addr >= REGION_MIRROR) mirrored[15] = 1'b0;

        entry = '0;
        if (mirrored < REGION_B_BASE) begin
            entry.bank  = BANK_A;
            entry.waddr = mirrored[15:2];
        end else if (mirrored < REGION_C_BASE) begin
            entry.bank  = BANK_B;
            entry.waddr = {2'b00, mirrored[13:2]};
        end else begin
            entry.bank  = BANK_C;
            entry.waddr = {2'b00, mirrored[13:2]};
        end

        // Byte writes into OBJ VRAM are ignored by the hardware; the BG split moves in bitmap modes.
        obj_boundary = (bgmode <= 3'd2) ? REGION_B_BASE : REGION_C_BASE;
        half_be      = mirrored[1] ? 4'b1100 : 4'b0011;
        drop         = 1'b0;

        case (cpu_wr_size)
            BYTE: begin
                entry.wdata = {4{cpu_wr_data[7:0]}};
                entry.be    = half_be;
                drop        = (mirrored >= obj_boundary);
            end
            HALF: begin
                entry.wdata = {2{cpu_wr_data[15:0]}};
                entry.be    = half_be;
            end
            default: begin
                entry.wdata = cpu_wr_data;
                entry.be    = 4'b1111;
            end
        endcase
    end

    assign cpu_wr_ready = !full;
    assign accept       = cpu_wr_valid && !full;
    assign push         = accept && !drop;
    assign pop          = vram_write_window && !empty;
    assign busy         = !empty;

    vram_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Registered bank stage: strobes are single-cycle, address/data hold between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            graphics_VRAM_A_we    <= 1'b0;
            graphics_VRAM_B_we    <= 1'b0;
            graphics_VRAM_C_we    <= 1'b0;
            graphics_VRAM_A_waddr <= '0;
            graphics_VRAM_B_waddr <= '0;
            graphics_VRAM_C_waddr <= '0;
            graphics_VRAM_A_wdata <= '0;
            graphics_VRAM_B_wdata <= '0;
            graphics_VRAM_C_wdata <= '0;
            graphics_VRAM_A_be    <= '0;
            graphics_VRAM_B_be    <= '0;
            graphics_VRAM_C_be    <= '0;
            wr_dropped            <= 1'b0;
        end else begin
            graphics_VRAM_A_we <= pop && (head.bank == BANK_A);
            graphics_VRAM_B_we <= pop && (head.bank == BANK_B);
            graphics_VRAM_C_we <= pop && (head.bank == BANK_C);
            wr_dropped         <= accept && drop;

            if (pop && head.bank == BANK_A) begin
                graphics_VRAM_A_waddr <= head.waddr;
                graphics_VRAM_A_wdata <= head.wdata;
                graphics_VRAM_A_be    <= head.be;
            end
            if (pop && head.bank == BANK_B) begin
                graphics_VRAM_B_waddr <= head.waddr[11:0];
                graphics_VRAM_B_wdata <= head.wdata;
                graphics_VRAM_B_be    <= head.be;
            end
            if (pop && head.bank == BANK_C) begin
                graphics_VRAM_C_waddr <= head.waddr[11:0];
                graphics_VRAM_C_wdata <= head.wdata;
                graphics_VRAM_C_be    <= head.be;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_controller.sv
// Bench for vram_write_controller: directed scenarios plus randomized traffic against an address-arithmetic model.
module tb_vram_write_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_wr_valid = 1'b0;
    logic        cpu_wr_ready;
    logic [16:0] cpu_wr_addr = '0;
    logic [1:0]  cpu_wr_size = '0;
    logic [31:0] cpu_wr_data = '0;
    logic [2:0]  bgmode = '0;
    logic        vram_write_window;
    logic [13:0] A_waddr;
    logic [11:0] B_waddr, C_waddr;
    logic [31:0] A_wdata, B_wdata, C_wdata;
    logic [3:0]  A_be, B_be, C_be;
    logic        A_we, B_we, C_we;
    logic        wr_dropped, busy;

    logic win_set = 1'b0, rand_en = 1'b0, rand_win = 1'b0;
    assign vram_write_window = rand_en ? rand_win : win_set;

    always #5 clock = ~clock;

    vram_write_controller #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_size(cpu_wr_size), .cpu_wr_data(cpu_wr_data),
        .bgmode(bgmode), .vram_write_window(vram_write_window),
        .graphics_VRAM_A_waddr(A_waddr), .graphics_VRAM_B_waddr(B_waddr), .graphics_VRAM_C_waddr(C_waddr),
        .graphics_VRAM_A_wdata(A_wdata), .graphics_VRAM_B_wdata(B_wdata), .graphics_VRAM_C_wdata(C_wdata),
        .graphics_VRAM_A_be(A_be), .graphics_VRAM_B_be(B_be), .graphics_VRAM_C_be(C_be),
        .graphics_VRAM_A_we(A_we), .graphics_VRAM_B_we(B_we), .graphics_VRAM_C_we(C_we),
        .wr_dropped(wr_dropped), .busy(busy)
    );

    typedef struct {
        int          bank;
        int          waddr;
        logic [31:0] data;
        logic [3:0]  be;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  exp_drops = 0, obs_drops = 0;
    bit  multi_we = 0;
    int  cyc = 0;
    int  errors = 0, checks = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        wr_t w;
        if (!reset) begin
            if (int'(A_we) + int'(B_we) + int'(C_we) > 1) multi_we = 1;
            w.cyc = cyc;
            if (A_we) begin w.bank = 0; w.waddr = int'(A_waddr); w.data = A_wdata; w.be = A_be; obs_q.push_back(w); end
            if (B_we) begin w.bank = 1; w.waddr = int'(B_waddr); w.data = B_wdata; w.be = B_be; obs_q.push_back(w); end
            if (C_we) begin w.bank = 2; w.waddr = int'(C_waddr); w.data = C_wdata; w.be = C_be; obs_q.push_back(w); end
            if (wr_dropped) obs_drops++;
        end
    end

    always @(posedge clock) begin
        #1 rand_win = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    // Reference: byte offsets and plain arithmetic, no bit-level decode.
    function automatic void model(input logic [16:0] addr, input logic [1:0] size, input logic [31:0] data,
                                  input logic [2:0] bgm, output bit drop, output wr_t w);
        int a, base, nbytes, off, boundary;
        logic [15:0] hw;
        a = int'(addr);
        if (a >= 'h18000) a = a - 'h8000;
        nbytes   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        boundary = (int'(bgm) <= 2) ? 'h10000 : 'h14000;
        drop     = (nbytes == 1) && (a >= boundary);
        if (a < 'h10000)      begin w.bank = 0; base = 0;       end
        else if (a < 'h14000) begin w.bank = 1; base = 'h10000; end
        else                  begin w.bank = 2; base = 'h14000; end
        off = a - base;
        w.waddr = off / 4;
        w.cyc = 0;
        if (nbytes == 4) begin
            w.data = data; w.be = 4'hF;
        end else begin
            hw = (nbytes == 1) ? {data[7:0], data[7:0]} : data[15:0];
            if ((off % 4) >= 2) begin w.data = {hw, 16'h0}; w.be = 4'hC; end
            else                begin w.data = {16'h0, hw}; w.be = 4'h3; end
        end
    endfunction

    function automatic logic [31:0] bemask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one write (called just after a rising edge); returns once accepted or timed out.
    task automatic send(input logic [16:0] addr, input logic [1:0] size, input logic [31:0] data,
                        input logic [2:0] bgm, output bit ok);
        bit r, d;
        wr_t w;
        cpu_wr_addr = addr; cpu_wr_size = size; cpu_wr_data = data; bgmode = bgm;
        cpu_wr_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            r = cpu_wr_ready;
            @(posedge clock);
            #1;
            if (r) ok = 1;
        end
        cpu_wr_valid = 1'b0;
        if (ok) begin
            model(addr, size, data, bgm, d, w);
            if (d) exp_drops++;
            else exp_q.push_back(w);
        end
    endtask

    task automatic test_reset();
        win_set = 0; rand_en = 0;
        repeat (2) @(negedge clock);
        checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cpu_wr_ready); end
        checks++; if (busy !== 1'b0 || wr_dropped !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b dropped=%b want 0 0", busy, wr_dropped); end
        checks++; if ({A_we, B_we, C_we, A_be, B_be, C_be} !== 15'd0) begin errors++; $display("FAIL reset_we_be: got %b want 0", {A_we, B_we, C_we, A_be, B_be, C_be}); end
        checks++; if ({A_waddr, B_waddr, C_waddr} !== 38'd0 || {A_wdata, B_wdata, C_wdata} !== 96'd0) begin
            errors++; $display("FAIL reset_addr_data: got %h %h want 0", {A_waddr, B_waddr, C_waddr}, {A_wdata, B_wdata, C_wdata}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_word();
        bit ok;
        win_set = 1;
        send(17'h00104, 2'd2, 32'hDEADBEEF, 3'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL word_accept: timed out, want accepted"); end
        @(negedge clock);
        checks++; if (A_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL word_early: we=%b busy=%b want 0 1", A_we, busy); end
        @(negedge clock);
        checks++; if (A_we !== 1'b1 || A_waddr !== 14'h0041 || A_be !== 4'hF || A_wdata !== 32'hDEADBEEF || B_we !== 1'b0 || C_we !== 1'b0) begin
            errors++; $display("FAIL word_strobe: we=%b addr=%h be=%h data=%h want 1 0041 f deadbeef", A_we, A_waddr, A_be, A_wdata); end
        @(negedge clock);
        checks++; if (A_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL word_after: we=%b busy=%b want 0 0", A_we, busy); end
        tick();
    endtask

    task automatic test_byte();
        bit ok;
        int n;
        send(17'h13001, 2'd0, 32'h0000005A, 3'd3, ok);
        @(negedge clock);
        @(negedge clock);
        checks++; if (B_we !== 1'b1 || B_waddr !== 12'hC00 || B_be !== 4'h3 || B_wdata[15:0] !== 16'h5A5A) begin
            errors++; $display("FAIL byte_bg: we=%b addr=%h be=%h data=%h want 1 c00 3 5a5a", B_we, B_waddr, B_be, B_wdata[15:0]); end
        tick();
        n = obs_q.size();
        send(17'h13001, 2'd0, 32'h0000005A, 3'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL byte_obj_accept: timed out, want accepted"); end
        @(negedge clock);
        checks++; if (wr_dropped !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL byte_obj_drop: dropped=%b busy=%b want 1 0", wr_dropped, busy); end
        @(negedge clock);
        checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL byte_drop_pulse: got %b want 0", wr_dropped); end
        repeat (3) @(negedge clock);
        checks++; if (obs_q.size() != n) begin errors++; $display("FAIL byte_obj_nostrobe: strobes %0d want %0d", obs_q.size(), n); end
        tick();
    endtask

    task automatic test_half_mirror();
        bit ok;
        send(17'h1C002, 2'd1, 32'h00001234, 3'd0, ok);
        @(negedge clock);
        @(negedge clock);
        checks++; if (C_we !== 1'b1 || C_waddr !== 12'h000 || C_be !== 4'hC || C_wdata[31:16] !== 16'h1234 || A_we !== 1'b0 || B_we !== 1'b0) begin
            errors++; $display("FAIL half_mirror: we=%b addr=%h be=%h data=%h want 1 000 c 1234", C_we, C_waddr, C_be, C_wdata[31:16]); end
        tick();
    endtask

    task automatic test_full();
        bit ok;
        int nok = 0;
        win_set = 0; obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(17'($urandom_range(0, 'hFFFF)), 2'd2, $urandom, 3'd0, ok);
            if (ok) nok++;
        end
        checks++; if (nok != 4) begin errors++; $display("FAIL full_fill: accepted %0d want 4", nok); end
        cpu_wr_addr = 17'h00200; cpu_wr_size = 2'd2; cpu_wr_data = 32'h55555555; cpu_wr_valid = 1'b1;
        @(negedge clock);
        checks++; if (cpu_wr_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_ready: ready=%b busy=%b want 0 1", cpu_wr_ready, busy); end
        tick();
        @(negedge clock);
        checks++; if (cpu_wr_ready !== 1'b0 || obs_q.size() != 0) begin errors++; $display("FAIL full_hold: ready=%b strobes=%0d want 0 0", cpu_wr_ready, obs_q.size()); end
        tick();
        win_set = 1;
        send(17'h00200, 2'd2, 32'h55555555, 3'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_fifth: timed out, want accepted"); end
        repeat (8) @(negedge clock);
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL full_count: strobes %0d want 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].bank != exp_q[i].bank || obs_q[i].waddr != exp_q[i].waddr || obs_q[i].data !== exp_q[i].data || obs_q[i].be !== exp_q[i].be) begin
                errors++; $display("FAIL full_order[%0d]: got %0d/%h/%h want %0d/%h/%h", i, obs_q[i].bank, obs_q[i].waddr, obs_q[i].data, exp_q[i].bank, exp_q[i].waddr, exp_q[i].data); end
        end
        for (int i = 1; i < 4 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i].cyc != obs_q[0].cyc + i) begin errors++; $display("FAIL full_consecutive[%0d]: cycle %0d want %0d", i, obs_q[i].cyc, obs_q[0].cyc + i); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        win_set = 0; obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) send(17'($urandom_range(0, 'h1FFFF)), 2'd2, $urandom, 3'd0, ok);
        cpu_wr_addr = 17'h14010; cpu_wr_size = 2'd2; cpu_wr_data = 32'hA5A5F00D; cpu_wr_valid = 1'b1;
        win_set = 1;
        @(negedge clock);
        checks++; if (cpu_wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_pop_no_reopen: ready=%b want 0", cpu_wr_ready); end
        tick();
        checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen: ready=%b want 1", cpu_wr_ready); end
        send(17'h14010, 2'd2, 32'hA5A5F00D, 3'd0, ok);
        for (int i = 0; i < 7; i++) begin
            send(17'($urandom_range(0, 'h1FFFF)), 2'd2, $urandom, 3'd0, ok);
            checks++; if (!ok || busy !== 1'b1 || cpu_wr_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_steady[%0d]: ok=%0d busy=%b ready=%b want 1 1 1", i, ok, busy, cpu_wr_ready); end
        end
        repeat (10) @(negedge clock);
        checks++; if (obs_q.size() != exp_q.size() || exp_q.size() != 12) begin errors++; $display("FAIL b2b_count: strobes %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].bank != exp_q[i].bank || obs_q[i].waddr != exp_q[i].waddr || obs_q[i].data !== exp_q[i].data) begin
                errors++; $display("FAIL b2b_order[%0d]: got %0d/%h/%h want %0d/%h/%h", i, obs_q[i].bank, obs_q[i].waddr, obs_q[i].data, exp_q[i].bank, exp_q[i].waddr, exp_q[i].data); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        win_set = 0; obs_q.delete(); exp_q.delete();
        send(17'h00040, 2'd2, 32'h11111111, 3'd0, ok);
        send(17'h10040, 2'd2, 32'h22222222, 3'd0, ok);
        send(17'h14040, 2'd2, 32'h33333333, 3'd0, ok);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
        win_set = 1;
        @(posedge clock);
        #2;
        checks++; if ((A_we | B_we | C_we) !== 1'b1) begin errors++; $display("FAIL rst_mid_strobe: got %b%b%b want one set", A_we, B_we, C_we); end
        reset = 1'b1;
        #1;
        checks++; if ({A_we, B_we, C_we} !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_async: we=%b busy=%b want 000 0", {A_we, B_we, C_we}, busy); end
        repeat (2) @(negedge clock);
        obs_q.delete();
        reset = 1'b0;
        repeat (6) @(negedge clock);
        checks++; if (obs_q.size() != 0 || busy !== 1'b0 || cpu_wr_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_stale: strobes=%0d busy=%b ready=%b want 0 0 1", obs_q.size(), busy, cpu_wr_ready); end
        tick();
    endtask

    task automatic test_random();
        bit ok;
        obs_q.delete(); exp_q.delete(); exp_drops = 0; obs_drops = 0; multi_we = 0;
        rand_en = 1;
        for (int i = 0; i < 80; i++) begin
            send(17'($urandom_range(0, 'h1FFFF)), 2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)), ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_accept[%0d]: timed out, want accepted", i); end
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_en = 0; win_set = 1;
        for (int i = 0; i < 100 && busy; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain: busy=%b want 0", busy); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: strobes %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].bank != exp_q[i].bank || obs_q[i].waddr != exp_q[i].waddr || obs_q[i].be !== exp_q[i].be ||
                (obs_q[i].data & bemask(obs_q[i].be)) !== (exp_q[i].data & bemask(exp_q[i].be))) begin
                errors++; $display("FAIL rand_write[%0d]: got %0d/%h/%h/%h want %0d/%h/%h/%h", i,
                    obs_q[i].bank, obs_q[i].waddr, obs_q[i].be, obs_q[i].data, exp_q[i].bank, exp_q[i].waddr, exp_q[i].be, exp_q[i].data); end
        end
        checks++; if (obs_drops != exp_drops) begin errors++; $display("FAIL rand_drops: got %0d want %0d", obs_drops, exp_drops); end
        checks++; if (multi_we) begin errors++; $display("FAIL rand_one_hot_we: multiple strobes seen, want at most one"); end
        tick();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_mirror();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
